// File: rtl/uart_register_bridge.sv
// uart_register_bridge: parses SYNC-framed read/write command packets from a
// UART receive byte stream, drives a register file, and returns response packets.
// Optional inter-byte timeout is compiled in when BRIDGE_TIMEOUT_EN is defined.
module uart_register_bridge #(
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         READ_LATENCY   = 1,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic [7:0]  ipRxData,
    input  logic        ipRxValid,
    output logic        opRxReady,
    output logic [7:0]  opTxData,
    output logic        opTxValid,
    input  logic        ipTxReady,
    output logic [7:0]  opAddress,
    output logic [31:0] opWrData,
    output logic        opWrEnable,
    input  logic [31:0] ipRdData,
    output logic        opError
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [7:0]  addr_q, addr_d;
    logic [23:0] data_q, data_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] rsp_q, rsp_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_ready_q, rx_ready_d;
    logic        err_q, err_d;
    logic        rx_accept;
    logic [2:0]  tx_last;

`ifdef BRIDGE_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] to_cnt_q, to_cnt_d;
`endif

    assign rx_accept = ipRxValid && rx_ready_q;
    assign tx_last   = is_write_q ? 3'd2 : 3'd6;

    assign opRxReady  = rx_ready_q;
    assign opTxData   = tx_data_q;
    assign opTxValid  = tx_valid_q;
    assign opAddress  = addr_q;
    assign opWrData   = wr_data_q;
    assign opWrEnable = wr_en_q;
    assign opError    = err_q;

    function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic wr,
                                             input logic [7:0] addr, input logic [31:0] rsp);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = {7'd0, wr};
            3'd2:    b = addr;
            3'd3:    b = rsp[7:0];
            3'd4:    b = rsp[15:8];
            3'd5:    b = rsp[23:16];
            3'd6:    b = rsp[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Packet parser, register access sequencing and response emission.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rsp_d      = rsp_q;
        byte_cnt_d = byte_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rx_accept && ipRxData == SYNC_BYTE) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (rx_accept) begin
                    if (ipRxData[7:1] == 7'd0) begin
                        is_write_d = ipRxData[0];
                        state_d    = ST_ADDR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_accept) begin
                    addr_d = ipRxData;
                    if (is_write_q) begin
                        byte_cnt_d = 2'd0;
                        state_d    = ST_DATA;
                    end else begin
                        lat_cnt_d = 3'd0;
                        state_d   = ST_RD_WAIT;
                    end
                end
            end
            ST_DATA: begin
                if (rx_accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_data_d = {ipRxData, data_q};
                        wr_en_d   = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        data_d[8*byte_cnt_q +: 8] = ipRxData;
                    end
                end
            end
            ST_WRITE: begin
                tx_idx_d   = 3'd0;
                tx_valid_d = 1'b1;
                tx_data_d  = SYNC_BYTE;
                state_d    = ST_RESP;
            end
            ST_RD_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rsp_d      = ipRdData;
                    tx_idx_d   = 3'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                    state_d    = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                if (tx_valid_q && ipTxReady) begin
                    if (tx_idx_q == tx_last) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        tx_idx_d  = tx_idx_q + 3'd1;
                        tx_data_d = resp_byte(tx_idx_q + 3'd1, is_write_q, addr_q, rsp_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef BRIDGE_TIMEOUT_EN
        if (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA) begin
            if (rx_accept) begin
                to_cnt_d = 32'd0;
            end else if (to_cnt_q == TO_LAST) begin
                to_cnt_d = 32'd0;
                err_d    = 1'b1;
                state_d  = ST_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 32'd1;
            end
        end else if (state_q == ST_IDLE) begin
            to_cnt_d = 32'd0;
        end
`endif

        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_CMD) ||
                     (state_d == ST_ADDR) || (state_d == ST_DATA);
    end

    // State and output registers; reset discards any packet in progress.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 24'h0;
            wr_data_q  <= 32'h0;
            wr_en_q    <= 1'b0;
            rsp_q      <= 32'h0;
            byte_cnt_q <= 2'd0;
            lat_cnt_q  <= 3'd0;
            tx_idx_q   <= 3'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rx_ready_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            to_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rsp_q      <= rsp_d;
            byte_cnt_q <= byte_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
            err_q      <= err_d;
`ifdef BRIDGE_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

endmodule
